// File: rtl/player_input_controller.sv
// Pushbutton front end and turn sequencer for a two-player board game:
// synchronises and debounces three active-low keys, then drives one-cycle control pulses.
module player_input_controller #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] KEY,
  input  logic       engine_busy,
  input  logic       game_over,
  output logic       new_game,
  output logic       user_turn_done,
  output logic       draw_offer,
  output logic       black_to_play,
  output logic       white_to_play
);

  localparam int          NUM_KEYS = 3;
  localparam int          KEY_TURN = 0;
  localparam int          KEY_DRAW = 1;
  localparam int          KEY_NEW  = 2;
  localparam logic [17:0] CNT_LAST = 18'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BLACK_TURN = 2'd1,
    WHITE_TURN = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  // One registered press strobe per key, high for one cycle after a 1->0 stable transition.
  logic [NUM_KEYS-1:0] press_evt;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic        sync1_reg;
      logic        sync2_reg;
      logic        stable_reg;
      logic        stable_d_reg;
      logic        press_reg;
      logic [17:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= 1'b1;
          sync2_reg    <= 1'b1;
          stable_reg   <= 1'b1;
          stable_d_reg <= 1'b1;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= KEY[gi];
          sync2_reg    <= sync1_reg;
          stable_d_reg <= stable_reg;
          press_reg    <= stable_d_reg & ~stable_reg;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 18'd1;
          end
        end
      end

      assign press_evt[gi] = press_reg;
    end
  endgenerate

  logic   ev_new;
  logic   ev_turn;
  logic   ev_draw;
  state_t state_reg;
  logic   draw_used_reg;
  logic   new_game_reg;
  logic   user_turn_done_reg;
  logic   draw_offer_reg;
  logic   black_to_play_reg;
  logic   white_to_play_reg;

  assign ev_new  = press_evt[KEY_NEW];
  assign ev_turn = press_evt[KEY_TURN];
  assign ev_draw = press_evt[KEY_DRAW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      draw_used_reg      <= 1'b0;
      new_game_reg       <= 1'b0;
      user_turn_done_reg <= 1'b0;
      draw_offer_reg     <= 1'b0;
      black_to_play_reg  <= 1'b0;
      white_to_play_reg  <= 1'b0;
    end else begin
      new_game_reg       <= 1'b0;
      user_turn_done_reg <= 1'b0;
      draw_offer_reg     <= 1'b0;
      black_to_play_reg  <= 1'b0;
      white_to_play_reg  <= 1'b0;

      if (ev_new) begin
        new_game_reg      <= 1'b1;
        black_to_play_reg <= 1'b1;
        draw_used_reg     <= 1'b0;
        state_reg         <= BLACK_TURN;
      end else begin
        case (state_reg)
          BLACK_TURN, WHITE_TURN: begin
            // A result ends the game before any same-cycle key is honoured.
            if (game_over) begin
              state_reg <= GAME_OVER;
            end else if (ev_turn) begin
              // A coincident draw offer loses to turn-done even when the engine drops it.
              if (!engine_busy) begin
                user_turn_done_reg <= 1'b1;
                draw_used_reg      <= 1'b0;
                if (state_reg == BLACK_TURN) begin
                  white_to_play_reg <= 1'b1;
                  state_reg         <= WHITE_TURN;
                end else begin
                  black_to_play_reg <= 1'b1;
                  state_reg         <= BLACK_TURN;
                end
              end
            end else if (ev_draw && !draw_used_reg) begin
              draw_offer_reg <= 1'b1;
              draw_used_reg  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign new_game       = new_game_reg;
  assign user_turn_done = user_turn_done_reg;
  assign draw_offer     = draw_offer_reg;
  assign black_to_play  = black_to_play_reg;
  assign white_to_play  = white_to_play_reg;

endmodule

// File: tb/tb_player_input_controller.sv
// Scoreboard bench: stimulus queues hand-computed pulses with their expected edge;
// a monitor pops and compares whenever any output is high.
module tb_player_input_controller;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  // Output vector order: {new_game, user_turn_done, draw_offer, black_to_play, white_to_play}
  localparam logic [4:0] NONE     = 5'b00000;
  localparam logic [4:0] NEW_BLK  = 5'b10010;
  localparam logic [4:0] TURN_WHT = 5'b01001;
  localparam logic [4:0] TURN_BLK = 5'b01010;
  localparam logic [4:0] DRAW     = 5'b00100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] KEY = 3'b111;
  logic       engine_busy = 1'b0;
  logic       game_over = 1'b0;
  logic       new_game, user_turn_done, draw_offer, black_to_play, white_to_play;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [4:0] obs;

  player_input_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .KEY            (KEY),
    .engine_busy    (engine_busy),
    .game_over      (game_over),
    .new_game       (new_game),
    .user_turn_done (user_turn_done),
    .draw_offer     (draw_offer),
    .black_to_play  (black_to_play),
    .white_to_play  (white_to_play)
  );

  always #5 clk = ~clk;

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    obs = {new_game, user_turn_done, draw_offer, black_to_play, white_to_play};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse edge=%0d actual=none required=%b", sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    if (obs != NONE) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse edge=%0d actual=%b required=none", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.val != obs) begin
          failures++;
          $display("FAIL pulse edge=%0d actual=%b required=%b at edge %0d", cyc, obs, e.val, e.cyc);
        end else begin
          $display("pulse edge=%0d outputs=%b ok", cyc, obs);
        end
      end
    end
  end

  task automatic expect_at(input int edge_no, input logic [4:0] v);
    exp_t x;
    x.cyc = edge_no;
    x.val = v;
    if (v != NONE) sb.push_back(x);
  endtask

  // Press key k for 'hold' sampled edges, release, then let the release settle.
  task automatic press(input int k, input int hold, input logic [4:0] v, input string name);
    @(negedge clk);
    KEY[k] = 1'b0;
    expect_at(cyc + 1 + LAT, v);
    $display("press %s key=%0d hold=%0d expect=%b at_edge=%0d", name, k, hold, v, cyc + 1 + LAT);
    repeat (hold) @(negedge clk);
    KEY[k] = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({new_game, user_turn_done, draw_offer, black_to_play, white_to_play} != NONE) begin
        failures++;
        $display("FAIL reset_outputs actual=%b required=%b",
                 {new_game, user_turn_done, draw_offer, black_to_play, white_to_play}, NONE);
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    press(2, 10, NEW_BLK, "new_game");
    press(0, 10, TURN_WHT, "turn1");
    press(0, 10, TURN_BLK, "turn2");
    press(0, 10, TURN_WHT, "turn3");

    press(0, 3, NONE, "glitch3");
    engine_busy = 1'b1;
    press(0, 10, NONE, "turn_busy");
    engine_busy = 1'b0;

    // Still WHITE_TURN: one draw, then ignored, then next turn re-arms it.
    press(1, 10, DRAW, "draw1");
    press(1, 10, NONE, "draw2_same_turn");
    press(0, 10, TURN_BLK, "turn4");
    press(1, 10, DRAW, "draw_new_turn");

    @(negedge clk);
    game_over = 1'b1;
    $display("game_over asserted edge=%0d", cyc + 1);
    repeat (2) @(negedge clk);
    game_over = 1'b0;
    press(0, 10, NONE, "turn_game_over");
    press(1, 10, NONE, "draw_game_over");
    press(2, 10, NEW_BLK, "new_from_game_over");

    // Simultaneous KEY0+KEY2: new-game wins; simultaneous release gives nothing.
    @(negedge clk);
    KEY[0] = 1'b0;
    KEY[2] = 1'b0;
    expect_at(cyc + 1 + LAT, NEW_BLK);
    $display("press both key0+key2 expect=%b at_edge=%0d", NEW_BLK, cyc + 1 + LAT);
    repeat (20) @(negedge clk);
    KEY[0] = 1'b1;
    KEY[2] = 1'b1;
    $display("release both key0+key2 expect=none");
    repeat (15) @(negedge clk);

    // Reset mid-debounce of KEY1, key stays low: event arrives in IDLE and is dropped.
    KEY[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    $display("reset mid-debounce of key1 edge=%0d", cyc + 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (14) @(negedge clk);
    press(0, 10, NONE, "turn_idle");
    press(2, 10, NEW_BLK, "new_after_reset");

    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
